// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the F/D/E/M/W pipeline.
// Produces E-stage forward selects, stage stalls/flushes and event counters.
module hazard_ctrl #(
  parameter int AW     = 5,
  parameter int MD_LAT = 4,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rs1D,
  input  logic [AW-1:0]    rs2D,
  input  logic [AW-1:0]    rs1E,
  input  logic [AW-1:0]    rs2E,
  input  logic [AW-1:0]    rdE,
  input  logic [AW-1:0]    rdM,
  input  logic [AW-1:0]    rdW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             loadE,
  input  logic             mdopE,
  input  logic             pcsrcE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [CW-1:0] CLAST = CW'(MD_LAT - 1);

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic flush_d;
    logic flush_e;
    logic flush_m;
  } ctl_t;

  function automatic logic dep(
    input logic [AW-1:0] rs,
    input logic [AW-1:0] rd,
    input logic          we
  );
    return we && (rs != '0) && (rs == rd);
  endfunction

  function automatic logic [1:0] fsel(
    input logic [AW-1:0] rs,
    input logic [AW-1:0] rd_m,
    input logic          we_m,
    input logic [AW-1:0] rd_w,
    input logic          we_w
  );
    logic [1:0] s;
    s = 2'b00;
    if (dep(rs, rd_m, we_m))
      s = 2'b10;
    else if (dep(rs, rd_w, we_w))
      s = 2'b01;
    return s;
  endfunction

  logic [CW-1:0] cnt;
  logic          md_hold;
  logic          lw_haz;
  logic          raw_haz;
  logic          sel_rst;
  logic          sel_md;
  logic          sel_br;
  logic          sel_hz;
  ctl_t          ctl;

  assign md_hold = !rst && mdopE && (cnt != CLAST);
  assign md_busy = md_hold;

  assign lw_haz = loadE && regwriteE && (rdE != '0) &&
                  ((rdE == rs1D) || (rdE == rs2D));

  generate
    if (FWD_EN != 0) begin : g_fwd
      assign raw_haz = 1'b0;

      always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (!rst) begin
          forwardAE = fsel(rs1E, rdM, regwriteM, rdW, regwriteW);
          forwardBE = fsel(rs2E, rdM, regwriteM, rdW, regwriteW);
        end
      end
    end else begin : g_nofwd
      // Write-first regfile: only producers still in E or M conflict.
      assign raw_haz = dep(rs1D, rdE, regwriteE) ||
                       dep(rs2D, rdE, regwriteE) ||
                       dep(rs1D, rdM, regwriteM) ||
                       dep(rs2D, rdM, regwriteM);
      assign forwardAE = 2'b00;
      assign forwardBE = 2'b00;
    end
  endgenerate

  // One-hot priority: reset, md hold, redirect, data hazard.
  assign sel_rst = rst;
  assign sel_md  = md_hold;
  assign sel_br  = !rst && !md_hold && pcsrcE;
  assign sel_hz  = !rst && !md_hold && !pcsrcE &&
                   (lw_haz || raw_haz);

  always_comb begin
    ctl = '0;
    unique case (1'b1)
      sel_rst: begin
        ctl.flush_d = 1'b1;
        ctl.flush_e = 1'b1;
        ctl.flush_m = 1'b1;
      end
      sel_md: begin
        ctl.stall_f = 1'b1;
        ctl.stall_d = 1'b1;
        ctl.stall_e = 1'b1;
        ctl.flush_m = 1'b1;
      end
      sel_br: begin
        ctl.flush_d = 1'b1;
        ctl.flush_e = 1'b1;
      end
      sel_hz: begin
        ctl.stall_f = 1'b1;
        ctl.stall_d = 1'b1;
        ctl.flush_e = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

  assign stallF = ctl.stall_f;
  assign stallD = ctl.stall_d;
  assign stallE = ctl.stall_e;
  assign flushD = ctl.flush_d;
  assign flushE = ctl.flush_e;
  assign flushM = ctl.flush_m;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (md_hold)
      cnt <= cnt + 1'b1;
    else
      cnt <= '0;
  end

  // Saturating event counters; reset-forced flushes are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (ctl.stall_d && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if ((ctl.flush_d || ctl.flush_e) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random stimulus
// against a rule-level model; two configurations share the inputs.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       regwriteE, regwriteM, regwriteW;
  logic       loadE, mdopE, pcsrcE;

  logic        sfa, sda, sea, fda, fea, fma, busya;
  logic [1:0]  faa, fba;
  logic [15:0] sca, fca;
  logic        sfb, sdb, seb, fdb, feb, fmb, busyb;
  logic [1:0]  fab, fbb;
  logic [1:0]  scb, fcb;

  int total = 0;
  int bad = 0;
  int age_a, age_b, msc_a, mfc_a, msc_b, mfc_b;
  int s0, f0;

  always #5 clk = ~clk;

  hazard_ctrl #(.AW(5), .MD_LAT(4), .FWD_EN(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .loadE(loadE), .mdopE(mdopE), .pcsrcE(pcsrcE),
    .stallF(sfa), .stallD(sda), .stallE(sea),
    .flushD(fda), .flushE(fea), .flushM(fma),
    .forwardAE(faa), .forwardBE(fba), .md_busy(busya),
    .stall_cnt(sca), .flush_cnt(fca)
  );

  hazard_ctrl #(.AW(5), .MD_LAT(2), .FWD_EN(0), .CNT_W(2)) u_nf (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .loadE(loadE), .mdopE(mdopE), .pcsrcE(pcsrcE),
    .stallF(sfb), .stallD(sdb), .stallE(seb),
    .flushD(fdb), .flushE(feb), .flushM(fmb),
    .forwardAE(fab), .forwardBE(fbb), .md_busy(busyb),
    .stall_cnt(scb), .flush_cnt(fcb)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] msel(input logic [4:0] r);
    if (r != 0 && regwriteM && r == rdM) return 2'b10;
    if (r != 0 && regwriteW && r == rdW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit busy_reg(input logic [4:0] r);
    return r != 0 && ((regwriteE && r == rdE) ||
                      (regwriteM && r == rdM));
  endfunction

  // {sf,sd,se,fd,fe,fm,fa,fb,busy}
  function automatic logic [10:0] ref_ctl(input bit fwd, input int age,
                                          input int lat);
    logic sf, sd, se, fd, fe, fm, bz;
    logic [1:0] fa, fb;
    bit hold, lw, raw;
    {sf, sd, se, fd, fe, fm, bz} = '0;
    fa = 2'b00;
    fb = 2'b00;
    if (rst) return 11'b000_111_00_00_0;
    hold = mdopE && (age < lat - 1);
    lw = loadE && regwriteE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
    raw = !fwd && (busy_reg(rs1D) || busy_reg(rs2D));
    if (fwd) begin
      fa = msel(rs1E);
      fb = msel(rs2E);
    end
    if (hold) begin
      {sf, sd, se, fm, bz} = '1;
    end else if (pcsrcE) begin
      fd = 1'b1;
      fe = 1'b1;
    end else if (lw || raw) begin
      sf = 1'b1;
      sd = 1'b1;
      fe = 1'b1;
    end
    return {sf, sd, se, fd, fe, fm, fa, fb, bz};
  endfunction

  function automatic int sat(input int v, input int w);
    return (v >= (1 << w) - 1) ? (1 << w) - 1 : v + 1;
  endfunction

  task automatic look();
    logic [10:0] ea, eb;
    @(negedge clk);
    ea = ref_ctl(1'b1, age_a, 4);
    eb = ref_ctl(1'b0, age_b, 2);
    chk("ctl", {sfa, sda, sea, fda, fea, fma, faa, fba, busya}, ea);
    chk("ctl_nf", {sfb, sdb, seb, fdb, feb, fmb, fab, fbb, busyb}, eb);
    chk("scnt", sca, msc_a);
    chk("fcnt", fca, mfc_a);
    chk("scnt_nf", scb, msc_b);
    chk("fcnt_nf", fcb, mfc_b);
    if (rst) begin
      age_a = 0; age_b = 0;
      msc_a = 0; mfc_a = 0; msc_b = 0; mfc_b = 0;
    end else begin
      age_a = ea[0] ? age_a + 1 : 0;
      age_b = eb[0] ? age_b + 1 : 0;
      if (ea[9]) msc_a = sat(msc_a, 16);
      if (ea[7] || ea[6]) mfc_a = sat(mfc_a, 16);
      if (eb[9]) msc_b = sat(msc_b, 2);
      if (eb[7] || eb[6]) mfc_b = sat(mfc_b, 2);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rst = 1'b0;
    {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
    {regwriteE, regwriteM, regwriteW, loadE, mdopE, pcsrcE} = '0;
  endtask

  initial begin
    age_a = 0; age_b = 0;
    msc_a = 0; mfc_a = 0; msc_b = 0; mfc_b = 0;
    clr();
    rst = 1'b1;
    mdopE = 1'b1;
    look();
    chk("rst_flush", {fda, fea, fma}, 3'b111);
    chk("rst_stall", {sfa, sda, sea, busya}, 4'b0000);
    adv();
    look();
    adv();
    clr();
    look();
    chk("rst_cnt", sca, 0);
    adv();

    // forwarding priority M over W, x0 never forwards
    rdM = 5; regwriteM = 1; rdW = 5; regwriteW = 1; rs1E = 5;
    look(); chk("fwd_m", faa, 2'b10); chk("fwd_nf", fab, 2'b00); adv();
    regwriteM = 0;
    look(); chk("fwd_w", faa, 2'b01); adv();
    rs1E = 0;
    look(); chk("fwd_x0", faa, 2'b00); adv();

    // load-use: one stall cycle, then W forwarding
    clr();
    loadE = 1; regwriteE = 1; rdE = 7; rs2D = 7;
    look(); chk("lu_stall", {sfa, sda, fea}, 3'b111); s0 = sca; adv();
    clr();
    rdM = 7; regwriteM = 1; rs2D = 7;
    look(); chk("lu_rel", sda, 1'b0); chk("lu_cnt", sca, s0 + 1); adv();
    clr();
    rdW = 7; regwriteW = 1; rs2E = 7;
    look(); chk("lu_fwdw", fba, 2'b01); adv();
    clr();
    loadE = 1; regwriteE = 1; rdE = 0; rs2D = 0;
    look(); chk("lu_x0", {sfa, sda, fea}, 3'b000); adv();

    // redirect overrides load-use
    clr();
    loadE = 1; regwriteE = 1; rdE = 7; rs1D = 7; pcsrcE = 1;
    look();
    chk("br_ctl", {fda, fea, sfa, sda}, 4'b1100);
    s0 = sca; f0 = fca;
    adv();
    clr();
    look(); chk("br_fcnt", fca, f0 + 1); chk("br_scnt", sca, s0); adv();

    // multi-cycle op: 3 hold cycles, release, back-to-back op
    clr();
    mdopE = 1;
    for (int k = 0; k < 6; k++) begin
      look();
      chk("md_cnt", u_dut.cnt, k % 4);
      chk("md_busy", {busya, sfa, sda, sea, fma}, (k == 3) ? 5'b0 : 5'h1f);
      adv();
    end
    rst = 1;
    look(); chk("md_rst", {busya, sfa, sda, sea}, 4'b0000); adv();
    rst = 0;
    look(); chk("md_rcnt", u_dut.cnt, 0); chk("md_rbusy", busya, 1'b1); adv();
    clr();
    look(); adv();

    // no-forwarding RAW stall lasts while producer is in E then M
    clr();
    regwriteE = 1; rdE = 3; rs1D = 3;
    look(); chk("raw_e", {sdb, fab}, 3'b100); chk("raw_fwd", sda, 1'b0); adv();
    clr();
    regwriteM = 1; rdM = 3; rs1D = 3;
    look(); chk("raw_m", sdb, 1'b1); adv();
    clr();
    regwriteW = 1; rdW = 3; rs1D = 3;
    look(); chk("raw_w", sdb, 1'b0); adv();

    // 2-bit counter saturation
    clr();
    rst = 1;
    look(); adv();
    clr();
    regwriteE = 1; rdE = 3; rs1D = 3;
    repeat (5) begin look(); adv(); end
    look(); chk("sat_nf", scb, 2'd3); chk("sat_fwd", sca, 0); adv();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      rs1D = 5'($urandom_range(0, 3));
      rs2D = 5'($urandom_range(0, 3));
      rs1E = 5'($urandom_range(0, 3));
      rs2E = 5'($urandom_range(0, 3));
      rdE = 5'($urandom_range(0, 3));
      rdM = 5'($urandom_range(0, 3));
      rdW = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom_range(0, 1));
      regwriteM = 1'($urandom_range(0, 1));
      regwriteW = 1'($urandom_range(0, 1));
      loadE = ($urandom_range(0, 3) == 0);
      pcsrcE = ($urandom_range(0, 7) == 0);
      mdopE = mdopE ? ($urandom_range(0, 5) != 0)
                    : ($urandom_range(0, 7) == 0);
      look();
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
